serial_subtractor_ctrl: RTL and testbench
=========================================

// Module: serial_subtractor_ctrl
//
// PURPOSE
//  Bit-serial N-bit subtract controller built around one subtractor1 cell (A, B, Cin=borrow-in, Cout=borrow-out, Diff).
//  Latches two WIDTH-bit operands on a valid/ready handshake and feeds them LSB-first through the cell.
//  The borrow is chained in a flop, so one bit is processed per cycle.
//  Presents Diff/Bout on a held result handshake; the midterm datapath uses it as its area-minimal subtract unit.
//
// PARAMETERS
//  WIDTH   8   operand/result width in bits; legal range 2..32
//
// PORTS
//  clk          in   1      single clock, rising edge
//  reset        in   1      asynchronous, active-high reset
//  start_valid  in   1      operands + Bin presented
//  start_ready  out  1      controller can accept (IDLE only)
//  A            in   WIDTH  minuend, sampled on accept
//  B            in   WIDTH  subtrahend, sampled on accept
//  Bin          in   1      initial borrow-in to bit 0, sampled on accept
//  Diff         out  WIDTH  result A-B-Bin mod 2^WIDTH, registered
//  Bout         out  1      final borrow out of MSB (1 => unsigned A < B+Bin)
//  done_valid   out  1      result valid, held until taken
//  done_ready   in   1      consumer takes result
//  busy         out  1      high in SHIFT or DONE
//
// BEHAVIOUR
//  - Reset (async, any state): FSM=IDLE; start_ready=1; done_valid=0; busy=0.
//    Reset also clears Diff, Bout, the shift registers, the count and the borrow flop to 0.
//  - FSM states: IDLE, SHIFT, DONE.
//  - IDLE:
//    - start_ready=1.
//    - On start_valid: latch A->a_sh, B->b_sh, Bin->brw; set cnt=0; go to SHIFT.
//  - SHIFT:
//    - start_ready=0.
//    - Each cycle the cell gets A=a_sh[0], B=b_sh[0], Cin=brw.
//    - Cell Diff shifts into d_sh at the MSB; a_sh and b_sh shift right; brw<=Cout; cnt++.
//    - When cnt==WIDTH-1: copy final d_sh into Diff, set Bout<=Cout, go to DONE.
//  - DONE:
//    - done_valid=1.
//    - On done_ready: go to IDLE (done_valid low the next cycle).
//  - Latency: acceptance edge E0; done_valid rises after edge E0+WIDTH.
//    Minimum initiation interval is WIDTH+2 cycles.
//  - Backpressure: while done_valid=1 and done_ready=0, Diff/Bout/ovf are held stable.
//  - start_valid outside IDLE is ignored (start_ready=0); no queuing.
//    Operand changes after acceptance have no effect.
//  - DONE with done_ready and start_valid both high: only the result is taken; the new op is accepted the next cycle, in IDLE.
//  - Diff/Bout keep the last completed result through IDLE and SHIFT.
//    They update only on the SHIFT->DONE transition.
//  - Arithmetic: exact WIDTH-bit two's-complement wrap; no saturation. A=B with Bin=0 gives Diff=0, Bout=0.
//  - Reset mid-SHIFT: operation discarded, no done_valid pulse; a fresh op works normally after release.
//
// CONFIGURATION
//  SERIAL_SUB_OVF_EN defined:
//  - Adds output port ovf (1 bit), reset 0.
//  - At the MSB cycle, ovf is set to brw(into MSB) XOR Cout(out of MSB), i.e. signed overflow of A-B-Bin.
//  - ovf is registered with Diff and held with it.
//  SERIAL_SUB_OVF_EN undefined: no ovf port and no extra logic; all other behaviour is identical.
//
// TESTING
//  1. WIDTH=8, A=0x5A, B=0x23, Bin=0 -> Diff=0x37, Bout=0; done_valid exactly 8 cycles after accept edge.
//  2. A=0x00, B=0x01, Bin=0 -> Diff=0xFF, Bout=1; ovf=0 (macro on).
//  3. A=0x80, B=0x01, Bin=0 -> Diff=0x7F, Bout=0; ovf=1 (macro on). A=0x7F, B=0xFF -> Diff=0x80, ovf=1.
//  4. A=0x10, B=0x0F, Bin=1 -> Diff=0x00, Bout=0. A=0x00, B=0x00, Bin=1 -> Diff=0xFF, Bout=1.
//  5. done_ready=0 for 5 cycles in DONE, start_valid=1 throughout -> Diff, Bout and done_valid stable, start_ready=0.
//     Release -> IDLE, second op accepted one cycle later.
//  6. Assert reset during the 4th SHIFT cycle -> outputs zero immediately, start_ready=1 after release, no done_valid.
//     Next op A=0x05, B=0x03 -> Diff=0x02.

Source files
------------

// File: rtl/serial_subtractor_ctrl.sv
// ============================================================================
//  Module      : serial_subtractor_ctrl (+ subtractor1 cell)
//  Description : Bit-serial WIDTH-bit subtractor, one bit per cycle, LSB first,
//                with valid/ready handshakes on operands and result.
//                Optional macro SERIAL_SUB_OVF_EN adds a signed-overflow output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module subtractor1 (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Cout,
    output logic Diff
);
    // Borrow out when A < B + Cin for a single bit
    assign Diff = A ^ B ^ Cin;
    assign Cout = (~A & B) | (~(A ^ B) & Cin);
endmodule

module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             done_valid,
    input  logic             done_ready,
    output logic             busy
);

    localparam int c_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_d_sh;
    logic               r_brw;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;

    logic               w_cell_diff;
    logic               w_cell_bout;
    logic [WIDTH-1:0]   w_d_next;
    logic               w_last;
    logic               w_unused_lsb;

    subtractor1 u_cell (
        .A    (r_a_sh[0]),
        .B    (r_b_sh[0]),
        .Cin  (r_brw),
        .Cout (w_cell_bout),
        .Diff (w_cell_diff)
    );

    // The oldest slot of d_sh is overwritten before it is ever needed.
    assign w_d_next     = {w_cell_diff, r_d_sh[WIDTH-1:1]};
    assign w_unused_lsb = r_d_sh[0];
    assign w_last       = (r_cnt == c_CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_d_sh  <= '0;
            r_brw   <= 1'b0;
            r_cnt   <= '0;
            r_diff  <= '0;
            r_bout  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start_valid) begin
                        r_a_sh  <= A;
                        r_b_sh  <= B;
                        r_brw   <= Bin;
                        r_cnt   <= '0;
                        r_state <= c_SHIFT;
                    end
                end
                c_SHIFT: begin
                    r_d_sh <= w_d_next;
                    r_a_sh <= {1'b0, r_a_sh[WIDTH-1:1]};
                    r_b_sh <= {1'b0, r_b_sh[WIDTH-1:1]};
                    r_brw  <= w_cell_bout;
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_diff  <= w_d_next;
                        r_bout  <= w_cell_bout;
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (done_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic r_ovf;

    // Signed overflow: borrow into the MSB differs from borrow out of it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (r_state == c_SHIFT && w_last) begin
            r_ovf <= r_brw ^ w_cell_bout;
        end
    end

    assign ovf = r_ovf;
`endif

    assign Diff        = r_diff;
    assign Bout        = r_bout;
    assign start_ready = (r_state == c_IDLE);
    assign done_valid  = (r_state == c_DONE);
    assign busy        = (r_state != c_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed bench for serial_subtractor_ctrl with a result scoreboard (WIDTH=8).
`default_nettype none

module tb_serial_subtractor_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_valid;
    logic         start_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Bin;
    logic [W-1:0] Diff;
    logic         Bout;
    logic         ovf;
    logic         done_valid;
    logic         done_ready;
    logic         busy;

    serial_subtractor_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .A           (A),
        .B           (B),
        .Bin         (Bin),
        .Diff        (Diff),
        .Bout        (Bout),
`ifdef SERIAL_SUB_OVF_EN
        .ovf         (ovf),
`endif
        .done_valid  (done_valid),
        .done_ready  (done_ready),
        .busy        (busy)
    );

`ifndef SERIAL_SUB_OVF_EN
    assign ovf = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
    } exp_t;

    exp_t         sb[$];
    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] last_d   = '0;
    logic         last_b   = 1'b0;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        exp_t        m;
        logic [W:0]  r;
        int          s;
        r    = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        s    = int'($signed(a)) - int'($signed(b)) - int'(bin);
        m.d  = r[W-1:0];
        m.bo = r[W];
        m.ov = (s > 127) || (s < -128);
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one operand set through acceptance, then scramble the inputs.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        int n = 0;
        while (!start_ready && n < 40) begin
            tick();
            n++;
        end
        chk("start_ready_wait", {31'd0, start_ready}, 32'd1);
        start_valid = 1'b1;
        A = a;
        B = b;
        Bin = bin;
        tick();
        start_valid = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        Bin = ~bin;
        sb.push_back(model(a, b, bin));
    endtask

    // Called right after the accept edge; checks SHIFT-phase outputs and latency.
    task automatic wait_done();
        int n = 0;
        while (!done_valid && n < 40) begin
            chk("shift_busy", {31'd0, busy}, 32'd1);
            chk("shift_start_ready", {31'd0, start_ready}, 32'd0);
            chk("shift_diff_held", {24'd0, Diff}, {24'd0, last_d});
            chk("shift_bout_held", {31'd0, Bout}, {31'd0, last_b});
            tick();
            n++;
        end
        chk("latency", n, W);
    endtask

    task automatic take();
        exp_t e;
        chk("sb_nonempty", sb.size(), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("diff", {24'd0, Diff}, {24'd0, e.d});
            chk("bout", {31'd0, Bout}, {31'd0, e.bo});
`ifdef SERIAL_SUB_OVF_EN
            chk("ovf", {31'd0, ovf}, {31'd0, e.ov});
`endif
            last_d = e.d;
            last_b = e.bo;
        end
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        chk("done_valid_drop", {31'd0, done_valid}, 32'd0);
        chk("idle_start_ready", {31'd0, start_ready}, 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        start_op(a, b, bin);
        wait_done();
        take();
    endtask

    initial begin
        exp_t e;
        int   dv_seen;
        reset       = 1'b1;
        start_valid = 1'b0;
        done_ready  = 1'b0;
        A           = '0;
        B           = '0;
        Bin         = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        chk("rst_diff", {24'd0, Diff}, 32'd0);
        chk("rst_bout", {31'd0, Bout}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        chk("rst_start_ready", {31'd0, start_ready}, 32'd1);
        chk("rst_done_valid", {31'd0, done_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        run_op(8'h5A, 8'h23, 1'b0);
        run_op(8'h00, 8'h01, 1'b0);
        run_op(8'h80, 8'h01, 1'b0);
        run_op(8'h7F, 8'hFF, 1'b0);
        run_op(8'h10, 8'h0F, 1'b1);
        run_op(8'h00, 8'h00, 1'b1);
        run_op(8'hC3, 8'hC3, 1'b0);
        run_op(8'h01, 8'h80, 1'b1);
        for (int i = 0; i < 4; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom));
        end

        // Backpressure with a competing start request held high.
        start_op(8'h33, 8'h11, 1'b0);
        wait_done();
        e = sb[0];
        start_valid = 1'b1;
        A = 8'h44;
        B = 8'h04;
        Bin = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_diff", {24'd0, Diff}, {24'd0, e.d});
            chk("bp_bout", {31'd0, Bout}, {31'd0, e.bo});
            chk("bp_done_valid", {31'd0, done_valid}, 32'd1);
            chk("bp_start_ready", {31'd0, start_ready}, 32'd0);
        end
        void'(sb.pop_front());
        last_d = e.d;
        last_b = e.bo;
        done_ready = 1'b1;
        tick();
        done_ready = 1'b0;
        chk("bp_release_dv", {31'd0, done_valid}, 32'd0);
        chk("bp_release_idle", {31'd0, start_ready}, 32'd1);
        tick();
        start_valid = 1'b0;
        chk("bp_second_accept", {31'd0, busy}, 32'd1);
        sb.push_back(model(8'h44, 8'h04, 1'b0));
        wait_done();
        take();

        // Reset during the 4th SHIFT cycle.
        start_op(8'hAA, 8'h55, 1'b0);
        tick();
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_diff", {24'd0, Diff}, 32'd0);
        chk("mid_rst_bout", {31'd0, Bout}, 32'd0);
        chk("mid_rst_ovf", {31'd0, ovf}, 32'd0);
        chk("mid_rst_done_valid", {31'd0, done_valid}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        void'(sb.pop_back());
        tick();
        reset = 1'b0;
        last_d = '0;
        last_b = 1'b0;
        chk("post_rst_start_ready", {31'd0, start_ready}, 32'd1);
        dv_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done_valid) dv_seen++;
        end
        chk("post_rst_no_done", dv_seen, 32'd0);
        run_op(8'h05, 8'h03, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
